// File: rtl/datapath_seq_pkg.sv
// Shared encodings for the sequenced datapath: ALU function codes,
// memory access sizes and the sequencer state enum.
package datapath_seq_pkg;

    // ALU function select codes
    localparam logic [4:0] FsAnd  = 5'd0;
    localparam logic [4:0] FsOr   = 5'd1;
    localparam logic [4:0] FsAdd  = 5'd2;
    localparam logic [4:0] FsXor  = 5'd3;
    localparam logic [4:0] FsSub  = 5'd4;
    localparam logic [4:0] FsPassB = 5'd5;
    localparam logic [4:0] FsLsl  = 5'd6;
    localparam logic [4:0] FsLsr  = 5'd7;

    // Memory access sizes
    localparam logic [1:0] SizeByte  = 2'd0;
    localparam logic [1:0] SizeHalf  = 2'd1;
    localparam logic [1:0] SizeWord  = 2'd2;
    localparam logic [1:0] SizeDword = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMem,
        StWb
    } state_e;

endpackage

// File: rtl/regfile_nx.sv
// NUM_REGS x DATA_W register file: two operand read ports, one debug read
// port, one write port. With ZERO_REG_EN the top register reads as zero.
module regfile_nx #(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned ZERO_REG_EN = 1,
    localparam int unsigned REG_AW     = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] ra_a,
    output logic [DATA_W-1:0] rd_a,
    input  logic [REG_AW-1:0] ra_b,
    output logic [DATA_W-1:0] rd_b,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam logic [REG_AW-1:0] Xzr = REG_AW'(NUM_REGS - 1);
    localparam bit ZeroEn = (ZERO_REG_EN != 0);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Storage; writes aimed at XZR are dropped
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && !(ZeroEn && wa == Xzr)) begin
            regs_q[wa] <= wd;
        end
    end

    // Combinational read ports, XZR forced to zero
    always_comb begin
        rd_a     = regs_q[ra_a];
        rd_b     = regs_q[ra_b];
        dbg_data = regs_q[dbg_sel];
        if (ZeroEn && ra_a == Xzr)    rd_a     = '0;
        if (ZeroEn && ra_b == Xzr)    rd_b     = '0;
        if (ZeroEn && dbg_sel == Xzr) dbg_data = '0;
    end

endmodule

// File: rtl/datapath_seq.sv
// Sequenced LEGv8-style datapath: accepts one micro-op, then steps it
// through execute, optional memory access (req/ack with timeout) and
// writeback, pulsing done (with err) at the end.
module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ZERO_REG_EN = 1,
    parameter int unsigned MEM_TIMEOUT = 16,
    localparam int unsigned REG_AW     = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              uop_valid,
    output logic              uop_ready,
    input  logic [4:0]        uop_fs,
    input  logic [REG_AW-1:0] uop_sa,
    input  logic [REG_AW-1:0] uop_sb,
    input  logic [REG_AW-1:0] uop_da,
    input  logic              uop_b_sel,
    input  logic [DATA_W-1:0] uop_k,
    input  logic              uop_c0,
    input  logic              uop_reg_wr,
    input  logic              uop_set_flags,
    input  logic              uop_mem_rd,
    input  logic              uop_mem_wr,
    input  logic [1:0]        uop_mem_size,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic              err,
    output logic [3:0]        status,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned MSB   = DATA_W - 1;

    state_e state_q, state_d;

    // Latched micro-op
    logic [4:0]        fs_q;
    logic [REG_AW-1:0] sa_q, sb_q, da_q;
    logic              b_sel_q, c0_q, reg_wr_q, set_flags_q, mem_rd_q, mem_wr_q;
    logic [DATA_W-1:0] k_q;
    logic [1:0]        size_q;

    logic [DATA_W-1:0] result_q, wdata_q, load_q;
    logic [3:0]        status_q;
    logic              err_q;
    logic [TMO_W-1:0]  tmo_q;

    logic [DATA_W-1:0] rd_a, rd_b, op_b, alu_res, ld_ext, rf_wd;
    logic [DATA_W:0]   sum;
    logic              alu_c, alu_v, rf_we, mem_expired;
    logic [3:0]        alu_flags;

    regfile_nx #(
        .NUM_REGS    (NUM_REGS),
        .DATA_W      (DATA_W),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_regfile (
        .clock    (clock),
        .reset_n  (reset_n),
        .ra_a     (sa_q),
        .rd_a     (rd_a),
        .ra_b     (sb_q),
        .rd_b     (rd_b),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wa       (da_q),
        .wd       (rf_wd)
    );

    // ALU; carry/overflow only meaningful for ADD and SUB
    always_comb begin
        op_b    = b_sel_q ? k_q : rd_b;
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (fs_q)
            FsAnd:   alu_res = rd_a & op_b;
            FsOr:    alu_res = rd_a | op_b;
            FsXor:   alu_res = rd_a ^ op_b;
            FsPassB: alu_res = op_b;
            FsLsl:   alu_res = rd_a << op_b[SH_W-1:0];
            FsLsr:   alu_res = rd_a >> op_b[SH_W-1:0];
            FsAdd: begin
                sum     = {1'b0, rd_a} + {1'b0, op_b} + (DATA_W + 1)'(c0_q);
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (rd_a[MSB] == op_b[MSB]) && (alu_res[MSB] != rd_a[MSB]);
            end
            FsSub: begin
                sum     = {1'b0, rd_a} + {1'b0, ~op_b} + (DATA_W + 1)'(1);
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (rd_a[MSB] != op_b[MSB]) && (alu_res[MSB] != rd_a[MSB]);
            end
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[MSB], alu_res == '0, alu_c, alu_v};
    end

    // Zero-extend load data from the access width
    always_comb begin
        case (size_q)
            SizeByte: ld_ext = DATA_W'(mem_rdata[7:0]);
            SizeHalf: ld_ext = DATA_W'(mem_rdata[15:0]);
            SizeWord: ld_ext = DATA_W'(mem_rdata[31:0]);
            default:  ld_ext = mem_rdata;
        endcase
    end

    assign mem_expired = (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

    // Sequencer state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next state; conflicting load+store skips memory and faults in WB
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (uop_valid) state_d = StExec;
            StExec: begin
                if ((mem_rd_q ^ mem_wr_q)) state_d = StMem;
                else                       state_d = StWb;
            end
            StMem:  if (mem_ack || mem_expired) state_d = StWb;
            StWb:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Micro-op latch, execute results and memory handshake bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fs_q        <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            da_q        <= '0;
            b_sel_q     <= 1'b0;
            k_q         <= '0;
            c0_q        <= 1'b0;
            reg_wr_q    <= 1'b0;
            set_flags_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            size_q      <= '0;
            result_q    <= '0;
            wdata_q     <= '0;
            load_q      <= '0;
            status_q    <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (uop_valid) begin
                        fs_q        <= uop_fs;
                        sa_q        <= uop_sa;
                        sb_q        <= uop_sb;
                        da_q        <= uop_da;
                        b_sel_q     <= uop_b_sel;
                        k_q         <= uop_k;
                        c0_q        <= uop_c0;
                        reg_wr_q    <= uop_reg_wr;
                        set_flags_q <= uop_set_flags;
                        mem_rd_q    <= uop_mem_rd;
                        mem_wr_q    <= uop_mem_wr;
                        size_q      <= uop_mem_size;
                    end
                end
                StExec: begin
                    result_q <= alu_res;
                    wdata_q  <= rd_b;
                    err_q    <= mem_rd_q & mem_wr_q;
                    tmo_q    <= '0;
                    if (set_flags_q) status_q <= alu_flags;
                end
                StMem: begin
                    if (mem_ack) begin
                        if (mem_rd_q) load_q <= ld_ext;
                    end else if (mem_expired) begin
                        err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state so reset clears them at once
    always_comb begin
        uop_ready = (state_q == StIdle);
        mem_req   = (state_q == StMem);
        mem_we    = mem_req & mem_wr_q;
        mem_addr  = result_q[ADDR_W-1:0];
        mem_wdata = wdata_q;
        mem_size  = size_q;
        done      = (state_q == StWb);
        err       = done & err_q;
        status    = status_q;
        rf_we     = done & reg_wr_q & ~err_q;
        rf_wd     = mem_rd_q ? load_q : result_q;
    end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised, sequenced LEGv8-style datapath. Contains a register file, an operand B mux (register or constant) and an ALU.
- A bus-style memory port with a req/ack handshake replaces the shared tristate data bus.
- Accepts one micro-op at a time over a valid/ready handshake and steps it through execute, memory and writeback.
- Sits between the control unit (micro-op source) and the data memory.

Parameters:
- DATA_W, 64, datapath and register width.
- NUM_REGS, 32, register count; REG_AW = clog2(NUM_REGS).
- ADDR_W, 32, memory address width.
- ZERO_REG_EN, 1, when 1 the highest register (XZR) reads 0 and ignores writes.
- MEM_TIMEOUT, 16, cycles allowed from mem_req assertion to mem_ack before abort.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- uop_valid  in  1  micro-op present
- uop_ready  out  1  block can accept a micro-op
- uop_fs  in  5  ALU function select
- uop_sa, uop_sb, uop_da  in  REG_AW  source A, source B, destination
- uop_b_sel  in  1  0: B=reg[sb]; 1: B=uop_k
- uop_k  in  DATA_W  constant
- uop_c0  in  1  carry-in for ADD
- uop_reg_wr  in  1  write result to reg[da]
- uop_set_flags  in  1  update status
- uop_mem_rd, uop_mem_wr  in  1  memory load / store
- uop_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword
- mem_req  out  1  memory request
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  store data
- mem_size  out  2  access size
- mem_ack  in  1  request complete
- mem_rdata  in  DATA_W  load data
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done; op faulted
- status  out  4  {N,Z,C,V}
- dbg_sel  in  REG_AW  debug register select
- dbg_data  out  DATA_W  combinational reg[dbg_sel]

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE; all registers, status and the latched micro-op clear to 0.
  - mem_req, done and err go to 0 immediately.
- FSM states: IDLE, EXEC, MEM, WB.
- IDLE:
  - uop_ready=1.
  - On uop_valid, latch all uop_* fields and go to EXEC.
- EXEC (1 cycle):
  - Read reg[sa]; B comes from the mux.
  - Compute the ALU result into a result register.
  - If set_flags, update status on the same edge.
  - Next state:
    - mem_rd and mem_wr both set → WB with err, no access.
    - mem_rd or mem_wr set → MEM.
    - Otherwise → WB.
- ALU (FS encoding): 0 AND, 1 OR, 2 ADD (A+B+c0), 3 XOR, 4 SUB (A+~B+1), 5 PASS_B, 6 LSL, 7 LSR. Other codes give result 0.
  - Shifts use the low clog2(DATA_W) bits of B.
  - N = result MSB; Z = (result == 0).
  - C and V are valid for ADD/SUB only and are 0 for every other code.
- MEM:
  - mem_req=1.
  - mem_addr = result[ADDR_W-1:0]; mem_we = mem_wr; mem_wdata = reg[sb] as read in EXEC; mem_size = uop_mem_size.
  - All of these hold stable until mem_ack is sampled high.
  - On ack:
    - Loads latch mem_rdata zero-extended from the mem_size width.
    - Go to WB; mem_req deasserts on the next cycle.
  - A timeout counter starts at mem_req assertion. If it reaches MEM_TIMEOUT with no ack: drop mem_req, go to WB with err=1, suppress the register write.
- WB (1 cycle):
  - done=1, err as determined; go to IDLE.
  - When reg_wr is set and err=0, write reg[da] at the end of WB:
    - loads write the extended load data;
    - all other ops write the ALU result.
  - Writes to XZR (ZERO_REG_EN=1) are dropped.
- Latency:
  - Non-memory op: done is high in the 2nd cycle after the accept edge.
  - Memory op: 2 + ack latency.
  - Throughput: one micro-op per (latency+1) cycles. uop_ready is 0 outside IDLE, so no hazards.
- Status changes only in EXEC with set_flags.
- dbg_data reflects register contents after the write edge.

Decomposition:
- Package datapath_seq_pkg: FS code constants, state enum, mem_size codes.
- Sub-module regfile_nx (parametrised NUM_REGS × DATA_W, 2 read ports plus 1 debug read port, 1 write port, async reset, XZR option).
- ALU, FSM and memory sequencing stay in datapath_seq.

Test Plan:
- Reset, then uop ADD sa=XZR, b_sel=1, k=5, da=1, reg_wr → done 2 cycles after accept; dbg_sel=1 reads 5; status unchanged.
- SUB with reg1=5, k=5, set_flags → result 0, status N=0 Z=1 C=1 V=0. Write to da=31 → reg31 stays 0.
- Load: mem_rd, size=byte, addr=reg1+k=0x10. Memory acks after 3 cycles with rdata=0xFFFF_FFFF_FFFF_FFA5 → mem_req/addr held stable 3 cycles; reg[da]=0xA5; done 5 cycles after accept.
- Store: mem_wr with reg[sb]=0x1234 → mem_we=1, mem_wdata=0x1234; no register write.
- No mem_ack → mem_req drops after 16 cycles; done=1 with err=1; reg[da] unchanged.
- uop_mem_rd=uop_mem_wr=1 → no mem_req; done with err=1.
- reset_n low while in MEM → mem_req=0 immediately; uop_ready=1 after release; all registers 0.
- uop_valid held high while busy → no second accept until IDLE; back-to-back ops accept every 3 cycles.
